// File: rtl/rtc_pkg.sv
// Shared constants for the RTC timebase: millisecond count range and default clock.
package rtc_pkg;

    localparam int unsigned MS_PER_S       = 1000;
    localparam int unsigned MSEC_W         = 10;
    localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

    localparam logic [MSEC_W-1:0] MSEC_LAST = MSEC_W'(MS_PER_S - 1);

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: out stays high for WIDTH_CYC cycles after trig.
module pulse_stretch #(
    parameter int unsigned WIDTH_CYC = 1
) (
    input  logic clk_50m,
    input  logic reset_n,
    input  logic trig,
    input  logic kill,
    output logic out
);

    localparam int unsigned CNT_W = $clog2(WIDTH_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (kill) begin
            cnt_d = '0;
        end else if (trig) begin
            cnt_d = CNT_W'(WIDTH_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = (cnt_q != '0);

endmodule

// File: rtl/rtc_timer.sv
// Millisecond/second timebase with enable, clear, preset, PPS pulse and sticky alarm.
module rtc_timer
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
    parameter int unsigned SEC_W  = 16,
    parameter int unsigned PPS_W  = 1
) (
    input  logic              clk_50m,
    input  logic              reset_n,
    input  logic              en,
    input  logic              clr,
    input  logic              load,
    input  logic [SEC_W-1:0]  load_val,
    input  logic [SEC_W-1:0]  alarm_val,
    input  logic              alarm_ack,
    output logic [SEC_W-1:0]  second,
    output logic [MSEC_W-1:0] msec,
    output logic              tick_ms,
    output logic              pps,
    output logic              alarm
);

    localparam int unsigned DIV   = CLK_HZ / MS_PER_S;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    generate
        if ((CLK_HZ % MS_PER_S) != 0 || CLK_HZ < MS_PER_S || PPS_W < 1 || PPS_W >= CLK_HZ)
        begin : gen_bad_params
            $error("rtc_timer: illegal CLK_HZ/PPS_W combination");
        end
    endgenerate

    logic [DIV_W-1:0]  div_q, div_d;
    logic [MSEC_W-1:0] msec_q, msec_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic              tick_q, tick_d;
    logic              alarm_q, alarm_d;
    logic              sec_step;

    always_comb begin
        div_d    = div_q;
        msec_d   = msec_q;
        sec_d    = sec_q;
        tick_d   = 1'b0;
        sec_step = 1'b0;
        if (clr) begin
            div_d  = '0;
            msec_d = '0;
            sec_d  = '0;
        end else if (load) begin
            div_d  = '0;
            msec_d = '0;
            sec_d  = load_val;
        end else if (en) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_d = 1'b1;
                if (msec_q == MSEC_LAST) begin
                    msec_d   = '0;
                    sec_d    = sec_q + SEC_W'(1);
                    sec_step = 1'b1;
                end else begin
                    msec_d = msec_q + MSEC_W'(1);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Only a counted step may raise the alarm; a new match beats a simultaneous ack.
    always_comb begin
        alarm_d = alarm_q;
        if (sec_step && (sec_d == alarm_val)) begin
            alarm_d = 1'b1;
        end else if (alarm_ack) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            msec_q  <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            msec_q  <= msec_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            alarm_q <= alarm_d;
        end
    end

    pulse_stretch #(
        .WIDTH_CYC (PPS_W)
    ) u_pps (
        .clk_50m (clk_50m),
        .reset_n (reset_n),
        .trig    (sec_step),
        .kill    (clr),
        .out     (pps)
    );

    assign second  = sec_q;
    assign msec    = msec_q;
    assign tick_ms = tick_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_rtc_timer.sv
// Randomized bench for rtc_timer; two instances (PPS_W=1 and 3) share stimulus.
module tb_rtc_timer;

    localparam int CLK_HZ = 4000;
    localparam int SEC_W  = 4;
    localparam int DIV    = CLK_HZ / 1000;
    localparam int PPS_A  = 1;
    localparam int PPS_B  = 3;

    logic             clk_50m   = 1'b0;
    logic             reset_n   = 1'b0;
    logic             en        = 1'b0;
    logic             clr       = 1'b0;
    logic             load      = 1'b0;
    logic [SEC_W-1:0] load_val  = '0;
    logic [SEC_W-1:0] alarm_val = '0;
    logic             alarm_ack = 1'b0;

    logic [SEC_W-1:0] second_a, second_b;
    logic [9:0]       msec_a, msec_b;
    logic             tick_a, tick_b, pps_a, pps_b, alarm_a, alarm_b;

    always #5 clk_50m = ~clk_50m;

    rtc_timer #(.CLK_HZ(CLK_HZ), .SEC_W(SEC_W), .PPS_W(PPS_A)) u_dut_a (
        .clk_50m (clk_50m), .reset_n (reset_n), .en (en), .clr (clr), .load (load),
        .load_val (load_val), .alarm_val (alarm_val), .alarm_ack (alarm_ack),
        .second (second_a), .msec (msec_a), .tick_ms (tick_a), .pps (pps_a), .alarm (alarm_a)
    );

    rtc_timer #(.CLK_HZ(CLK_HZ), .SEC_W(SEC_W), .PPS_W(PPS_B)) u_dut_b (
        .clk_50m (clk_50m), .reset_n (reset_n), .en (en), .clr (clr), .load (load),
        .load_val (load_val), .alarm_val (alarm_val), .alarm_ack (alarm_ack),
        .second (second_b), .msec (msec_b), .tick_ms (tick_b), .pps (pps_b), .alarm (alarm_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: time is tracked as enabled cycles since the last clear/load/reset.
    longint m_total;
    longint m_cyc = 0;
    longint m_last_pps;
    int     m_base;
    bit     m_tick;
    bit     m_alarm;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, m_cyc, got, exp);
        end
    endtask

    function automatic int m_sec();
        return int'((longint'(m_base) + m_total / CLK_HZ) % (1 << SEC_W));
    endfunction

    function automatic int m_msec();
        return int'((m_total / DIV) % 1000);
    endfunction

    function automatic int m_pps(input int width);
        return ((m_cyc - m_last_pps) < width) ? 1 : 0;
    endfunction

    task automatic m_reset();
        m_base     = 0;
        m_total    = 0;
        m_tick     = 1'b0;
        m_alarm    = 1'b0;
        m_last_pps = -1000000;
    endtask

    task automatic m_edge();
        bit set_alarm;
        set_alarm = 1'b0;
        m_cyc++;
        if (!reset_n) begin
            m_reset();
            return;
        end
        m_tick = 1'b0;
        if (clr) begin
            m_base     = 0;
            m_total    = 0;
            m_last_pps = -1000000;
        end else if (load) begin
            m_base  = int'(load_val);
            m_total = 0;
        end else if (en) begin
            m_total++;
            m_tick = ((m_total % DIV) == 0);
            if ((m_total % CLK_HZ) == 0) begin
                m_last_pps = m_cyc;
                set_alarm  = (m_sec() == int'(alarm_val));
            end
        end
        if (set_alarm) m_alarm = 1'b1;
        else if (alarm_ack) m_alarm = 1'b0;
    endtask

    task automatic check_all();
        check_eq("second_a", 32'(second_a), m_sec());
        check_eq("msec_a",   32'(msec_a),   m_msec());
        check_eq("tick_a",   32'(tick_a),   int'(m_tick));
        check_eq("pps_a",    32'(pps_a),    m_pps(PPS_A));
        check_eq("alarm_a",  32'(alarm_a),  int'(m_alarm));
        check_eq("second_b", 32'(second_b), m_sec());
        check_eq("msec_b",   32'(msec_b),   m_msec());
        check_eq("tick_b",   32'(tick_b),   int'(m_tick));
        check_eq("pps_b",    32'(pps_b),    m_pps(PPS_B));
        check_eq("alarm_b",  32'(alarm_b),  int'(m_alarm));
    endtask

    task automatic step();
        @(posedge clk_50m);
        m_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_boundary(input string tag, input int limit);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            step();
            if (m_last_pps == m_cyc) hit = 1'b1;
        end
        check_eq(tag, 32'(hit), 1);
    endtask

    task automatic wait_pre_boundary(input string tag, input int limit);
        bit hit;
        hit = ((m_total % CLK_HZ) == CLK_HZ - 1);
        for (int i = 0; i < limit && !hit; i++) begin
            step();
            hit = ((m_total % CLK_HZ) == CLK_HZ - 1);
        end
        check_eq(tag, 32'(hit), 1);
    endtask

    initial begin
        m_reset();
        en = 1'b1;
        run(3);
        reset_n = 1'b1;

        // Free run through the first second; then a second PPS with en dropped mid-pulse.
        run(4100);
        wait_boundary("wait_pps2", 5000);
        en = 1'b0;
        run(2);
        en = 1'b1;
        run(10);
        en = 1'b0;
        run(7);
        en = 1'b1;
        run(20);

        // Rollover from 15 under ragged enable.
        load_val = 4'd15;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            step();
        end
        en = 1'b1;
        wait_boundary("wait_rollover", 5000);
        check_eq("rollover_second", 32'(second_b), 0);

        // Preset at msec 500.
        for (int i = 0; i < 5000 && m_msec() != 500; i++) step();
        check_eq("msec_500_reached", 32'(msec_b), 500);
        load_val = 4'd9;
        load = 1'b1;
        step();
        load = 1'b0;
        check_eq("load_second", 32'(second_b), 9);
        wait_boundary("wait_after_load", 4100);
        check_eq("load_next_second", 32'(second_b), 10);

        // Alarm set, hold, ack, ack racing a fresh match, and load onto the alarm value.
        alarm_val = 4'd2;
        load_val = 4'd1;
        load = 1'b1;
        step();
        load = 1'b0;
        wait_boundary("wait_alarm", 4100);
        check_eq("alarm_rise", 32'(alarm_b), 1);
        run(50);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check_eq("alarm_acked", 32'(alarm_b), 0);
        alarm_val = 4'(m_sec() + 1);
        wait_pre_boundary("wait_pre_match", 4100);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        check_eq("alarm_set_beats_ack", 32'(alarm_b), 1);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        alarm_val = 4'd2;
        load_val = 4'd2;
        load = 1'b1;
        step();
        load = 1'b0;
        check_eq("alarm_load_no_set", 32'(alarm_b), 0);
        run(20);

        // clr and load together while the wide pulse is active.
        wait_boundary("wait_pps_clr", 4100);
        step();
        clr = 1'b1;
        load = 1'b1;
        load_val = 4'd7;
        step();
        clr = 1'b0;
        load = 1'b0;
        check_eq("clr_wins_second", 32'(second_b), 0);
        check_eq("clr_kills_pps", 32'(pps_b), 0);

        // Randomized mix of all controls.
        for (int i = 0; i < 20000; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            clr       = ($urandom_range(0, 1999) == 0);
            load      = ($urandom_range(0, 1499) == 0);
            load_val  = 4'($urandom);
            alarm_ack = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 499) == 0) alarm_val = 4'($urandom);
            step();
        end
        en = 1'b1; clr = 1'b0; load = 1'b0; alarm_ack = 1'b0;

        // Async reset mid-millisecond.
        for (int i = 0; i < 10 && ((m_total % DIV) != 2 || m_msec() == 0); i++) step();
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        check_all();
        run(2);
        reset_n = 1'b1;
        run(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_timer.md
# rtc_timer

Parametrised second/millisecond timebase for the board's UART demo and other consumers needing wall-clock time. It divides the system clock into a 1 kHz tick and counts milliseconds and seconds, and emits a configurable-width PPS pulse. It also supports enable, synchronous clear, preset load and a sticky seconds alarm. It sits between the system clock and any block that timestamps, paces or reports time.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz; must be a multiple of 1000 and ≥ 1000
- SEC_W, 16, width of the seconds counter
- PPS_W, 1, PPS pulse width in clock cycles; 1 ≤ PPS_W < CLK_HZ
- clk_50m  in  1  system clock, single domain
- reset_n  in  1  asynchronous active-low reset
- en  in  1  count enable; low freezes the divider, msec and second
- clr  in  1  synchronous clear of divider, msec, second and PPS stretch
- load  in  1  synchronous preset of second from load_val
- load_val  in  SEC_W  preset value
- alarm_val  in  SEC_W  alarm compare value
- alarm_ack  in  1  clears the alarm flag
- second  out  SEC_W  seconds count, wraps 2^SEC_W−1 → 0
- msec  out  10  milliseconds within the second, 0..999
- tick_ms  out  1  one-cycle pulse per millisecond boundary
- pps  out  1  PPS_W-cycle pulse per second boundary
- alarm  out  1  sticky alarm flag

## Operation
- DIV = CLK_HZ/1000. The divider counts 0..DIV−1 on enabled cycles. A full millisecond is exactly DIV enabled cycles, with no extra cycle at the terminal.
- Divider terminal with en=1: on the next edge the divider goes to 0, tick_ms=1 and msec increments.
- When msec is 999 at that point, msec goes to 0, second increments (modulo 2^SEC_W) and the PPS stretch loads PPS_W.
- pps = (stretch ≠ 0). The stretch decrements every cycle regardless of en, so a pulse in progress always completes.
- Priority: clr > load > count.
- clr: divider, msec and second go to 0, the stretch goes to 0 (pps drops on the next edge), and tick_ms goes to 0. alarm is unaffected.
- load: second takes load_val, and divider and msec go to 0. No tick_ms, no pps, no alarm evaluation. The stretch keeps decrementing.
- en=0: all counters hold and tick_ms=0.
- Alarm: set on the edge where a count increments second to a value equal to alarm_val. Load or clr reaching alarm_val does not set it.
- alarm holds until alarm_ack. If set and ack occur on the same edge, set wins.
- Reset values: second=0, msec=0, tick_ms=0, pps=0, alarm=0, divider=0, stretch=0.
- Elaboration fails if CLK_HZ%1000≠0, CLK_HZ<1000, PPS_W<1 or PPS_W≥CLK_HZ.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- After reset release with en held high, tick_ms is high in the cycle after the DIV-th rising edge, and then every DIV cycles.
- The first pps pulse starts after CLK_HZ enabled edges, in the same cycle that second shows 1, msec shows 0 and tick_ms is high.
- pps is high for exactly PPS_W consecutive cycles.
- alarm rises in the same cycle second shows the matching value.
- en deasserted for N cycles delays every later tick by exactly N cycles.
- clr, load and alarm_ack take effect on the next edge, with one-cycle latency.
- Reset mid-pulse drops pps asynchronously. Reset mid-millisecond discards the partial count.

## Structure
- Shared package or include rtc_pkg: MS_PER_S=1000, MSEC_W=10, default CLK_HZ. The divider width is derived as clog2(DIV) and the stretch width as clog2(PPS_W+1).
- One sub-module, pulse_stretch (parameter WIDTH_CYC; ports clk_50m, reset_n, trig, kill, out), used for pps.
- The divider, msec/second counters and alarm logic live in rtc_timer.

## Test plan
All scenarios use CLK_HZ=4000 (DIV=4) and SEC_W=4.
- Reset release, en=1, PPS_W=1 → tick_ms every 4 cycles; first pps after 4000 cycles with second=1, msec=0; pps high for exactly 1 cycle.
- PPS_W=3, run 2 s → two pps pulses, each 3 cycles wide, 4000 cycles apart. Drop en during a pulse → the pulse still lasts 3 cycles.
- second=15 at rollover → second=0 and pps fires. en low for 7 cycles → next tick_ms is delayed by exactly 7 cycles.
- load=1, load_val=9 at msec=500 → second=9, msec=0, no pps. Next pps comes 4000 enabled cycles later with second=10.
- alarm_val=2 → alarm rises with second=2 and holds. alarm_ack on the same cycle as a fresh match → alarm stays 1. load to 2 → alarm does not set.
- clr and load together during a pps pulse → all counts 0 (clr wins) and pps low next cycle. Async reset_n low mid-millisecond → all outputs 0 immediately.
